cmp_ou_pipelined: RTL
=====================

// Module: cmp_ou_pipelined
// PURPOSE
//  Parametrised, pipelined compare/select operation unit for the RCA fabric; next generation of the single-cycle
//  signed-less-than OU. Supports eight runtime-selected ops (signed/unsigned lt, min, max, eq, ne) at WIDTH bits.
//  Has an elastic PIPE_DEPTH-stage pipeline with output backpressure and sustains one op/cycle.
//  Sits in a PR slot between fabric input/output links; never issues LSQ traffic.
// PARAMETERS
//  WIDTH       32  operand/result width in bits (>=2)
//  PIPE_DEPTH  2   number of register stages from operand accept to data_valid_out (>=1)
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous, active-low reset (0 = reset)
//  data_in1        in   WIDTH  operand A
//  data_in2        in   WIDTH  operand B
//  data_valid_in1  in   1      operand A valid
//  data_valid_in2  in   1      operand B valid
//  op_sel          in   3      cmp_op_t; sampled with operands on accept
//  data_in_ack1    out  1      operand A consumed this cycle
//  data_in_ack2    out  1      operand B consumed this cycle
//  uses_data_in1   out  1      constant 1
//  uses_data_in2   out  1      constant 1
//  data_out        out  WIDTH  result of the oldest op
//  data_valid_out  out  1      data_out valid
//  data_out_ack    in   1      downstream consumes data_out when high with data_valid_out
//  ops_completed   out  32     output handshake count (see CONFIGURATION)
//  addr,data       out  XLEN   LSQ, tied 0
//  fn3             out  3      LSQ, tied 0
//  load,store      out  1      LSQ, tied 0
//  new_request     out  1      LSQ, tied 0
//  lsq_full,load_data,load_complete  in  -  LSQ, ignored
// BEHAVIOUR
//  - Reset (rst==0 at a posedge): all stage valids clear, stage data 0, ops_completed 0. In-flight ops are dropped.
//    No ack is asserted during reset. Outputs read 0 on the cycle after reset.
//  - Stage k advances when it is empty, or the next stage advances. Last stage advances on data_out_ack.
//  - Accept: fire = data_valid_in1 && data_valid_in2 && stage0_advances.
//    data_in_ack1 = data_in_ack2 = fire (combinational). A single valid operand is never acked.
//  - Result computed combinationally from the inputs and registered into stage 0 on fire.
//    Stages 1..PIPE_DEPTH-1 only carry it.
//  - Latency: PIPE_DEPTH cycles from fire to data_valid_out with no backpressure.
//    Throughput: 1 op/cycle while data_out_ack is held high.
//  - data_valid_out = last-stage valid. data_out holds stable while data_valid_out && !data_out_ack.
//  - Full: all stages valid and data_out_ack=0 -> no fire. Full with data_out_ack=1 -> fire allowed the same cycle.
//  - Ops: SLT/SLTU give {WIDTH-1 zeros, A<B}, signed/unsigned. MIN/MINU/MAX/MAXU return the selected operand.
//    Ties return A. EQ/NE give a zero-extended 1-bit flag.
//  - No overflow possible: pure compare, no arithmetic widening.
// CONFIGURATION
//  - CMP_OU_STATS_EN defined: ops_completed increments on each data_valid_out && data_out_ack and saturates
//    at 32'hFFFF_FFFF.
//  - Not defined: ops_completed is tied 32'd0 and the counter is not synthesised.
// STRUCTURE
//  - Shared package rca_config: typedef enum logic [2:0] cmp_op_t
//    {CMP_SLT=0, CMP_SLTU=1, CMP_MIN=2, CMP_MINU=3, CMP_MAX=4, CMP_MAXU=5, CMP_EQ=6, CMP_NE=7}
//    and CMP_OU_DEFAULT_DEPTH=2.
//  - Sub-module cmp_ou_pipe_stage: one elastic valid/data register with in_valid, in_ready, out_valid, out_ready.
//    The top instantiates PIPE_DEPTH of these in a generate loop.
// TESTING
//  1. Reset with rst=0 for 2 cycles, with inputs valid -> no acks, data_valid_out=0, data_out=0, ops_completed=0.
//  2. WIDTH=32, PIPE_DEPTH=2, ack held 1, A=32'hFFFF_FFFF, B=1:
//     SLT->1, SLTU->0, MIN->FFFF_FFFF, MAXU->FFFF_FFFF, EQ->0.
//     Results appear exactly 2 cycles after each fire, back-to-back.
//  3. Only data_valid_in1 high for 5 cycles -> no ack. Raise data_valid_in2 -> both acks the same cycle.
//  4. data_out_ack=0, stream 4 ops -> exactly 2 acked, then stall with data_out stable.
//     Raise ack -> each drained op admits a new one the same cycle, and order is preserved.
//  5. Drop rst mid-stream with 2 ops in flight -> both lost, valid_out=0 next cycle.
//     A new op after release returns in 2 cycles.
//  6. With CMP_OU_STATS_EN: 10 output handshakes -> ops_completed=10.
//     Without it: ops_completed=0 throughout.

Source files
------------

// File: rtl/rca_config_pkg.sv
// Shared RCA fabric configuration: compare-op encoding and default
// pipeline depth for the compare/select operation unit.
package rca_config;

    typedef enum logic [2:0] {
        CMP_SLT  = 3'd0,
        CMP_SLTU = 3'd1,
        CMP_MIN  = 3'd2,
        CMP_MINU = 3'd3,
        CMP_MAX  = 3'd4,
        CMP_MAXU = 3'd5,
        CMP_EQ   = 3'd6,
        CMP_NE   = 3'd7
    } cmp_op_t;

    localparam int CMP_OU_DEFAULT_DEPTH = 2;

endpackage

// File: rtl/cmp_ou_pipe_stage.sv
// One elastic pipeline slot: a valid/data register that accepts new data
// whenever it is empty or its contents are leaving this cycle.
module cmp_ou_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Slot register: load on advance, hold data while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cmp_ou_pipelined.sv
// Pipelined compare/select operation unit for the RCA fabric.
// Eight runtime-selected ops (signed/unsigned lt, min, max, eq, ne), result
// computed at accept and carried through PIPE_DEPTH elastic slots.
// Optional feature: define CMP_OU_STATS_EN to build the saturating
// ops_completed handshake counter; otherwise ops_completed reads 0.
module cmp_ou_pipelined
    import rca_config::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = CMP_OU_DEFAULT_DEPTH,
    parameter int XLEN       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             data_valid_in1,
    input  logic             data_valid_in2,
    input  logic [2:0]       op_sel,
    output logic             data_in_ack1,
    output logic             data_in_ack2,
    output logic             uses_data_in1,
    output logic             uses_data_in2,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    input  logic             data_out_ack,
    output logic [31:0]      ops_completed,
    output logic [XLEN-1:0]  addr,
    output logic [XLEN-1:0]  data,
    output logic [2:0]       fn3,
    output logic             load,
    output logic             store,
    output logic             new_request,
    input  logic             lsq_full,
    input  logic [XLEN-1:0]  load_data,
    input  logic             load_complete
);

    // Compare/select result; ties on min/max return operand A.
    function automatic logic [WIDTH-1:0] cmp_result(cmp_op_t op,
                                                    logic [WIDTH-1:0] a,
                                                    logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic                    lt_s;
        logic                    lt_u;
        logic                    gt_s;
        logic                    gt_u;
        a_s  = a;
        b_s  = b;
        lt_s = a_s < b_s;
        gt_s = b_s < a_s;
        lt_u = a < b;
        gt_u = b < a;
        case (op)
            CMP_SLT:  cmp_result = {{(WIDTH-1){1'b0}}, lt_s};
            CMP_SLTU: cmp_result = {{(WIDTH-1){1'b0}}, lt_u};
            CMP_MIN:  cmp_result = gt_s ? b : a;
            CMP_MINU: cmp_result = gt_u ? b : a;
            CMP_MAX:  cmp_result = lt_s ? b : a;
            CMP_MAXU: cmp_result = lt_u ? b : a;
            CMP_EQ:   cmp_result = {{(WIDTH-1){1'b0}}, (a == b)};
            CMP_NE:   cmp_result = {{(WIDTH-1){1'b0}}, (a != b)};
            default:  cmp_result = '0;
        endcase
    endfunction

    logic                  both_valid;
    logic                  fire;
    logic [WIDTH-1:0]      result_p0;
    logic [PIPE_DEPTH-1:0] vld_p;
    logic [PIPE_DEPTH-1:0] rdy_p;
    logic [PIPE_DEPTH-1:0] down_rdy_p;
    logic [WIDTH-1:0]      dat_p [PIPE_DEPTH];

    assign both_valid = data_valid_in1 && data_valid_in2;
    assign result_p0  = cmp_result(cmp_op_t'(op_sel), data_in1, data_in2);

    // Reset gates the accept so nothing is acked while rst is low.
    assign fire         = rst && both_valid && rdy_p[0];
    assign data_in_ack1 = fire;
    assign data_in_ack2 = fire;

    assign uses_data_in1 = 1'b1;
    assign uses_data_in2 = 1'b1;

    // Downstream readiness is derived from slot valids directly rather than
    // chained through each slot's in_ready, keeping the ready path acyclic:
    // a slot can move when any later slot is empty or the output is taken.
    genvar k;
    generate
        for (k = 0; k < PIPE_DEPTH; k++) begin : g_stage
            if (k == PIPE_DEPTH - 1) begin : g_last
                assign down_rdy_p[k] = data_out_ack;
            end else begin : g_mid
                assign down_rdy_p[k] = data_out_ack || !(&vld_p[PIPE_DEPTH-1:k+1]);
            end

            if (k == 0) begin : g_head
                cmp_ou_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .in_valid  (both_valid),
                    .in_ready  (rdy_p[k]),
                    .in_data   (result_p0),
                    .out_valid (vld_p[k]),
                    .out_data  (dat_p[k]),
                    .out_ready (down_rdy_p[k])
                );
            end else begin : g_tail
                cmp_ou_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .in_valid  (vld_p[k-1]),
                    .in_ready  (rdy_p[k]),
                    .in_data   (dat_p[k-1]),
                    .out_valid (vld_p[k]),
                    .out_data  (dat_p[k]),
                    .out_ready (down_rdy_p[k])
                );
            end
        end
    endgenerate

    assign data_valid_out = vld_p[PIPE_DEPTH-1];
    assign data_out       = dat_p[PIPE_DEPTH-1];

`ifdef CMP_OU_STATS_EN
    logic [31:0] ops_cnt;

    // Saturating count of output handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ops_cnt <= 32'd0;
        end else if (data_valid_out && data_out_ack && (ops_cnt != 32'hFFFF_FFFF)) begin
            ops_cnt <= ops_cnt + 32'd1;
        end
    end

    assign ops_completed = ops_cnt;
`else
    assign ops_completed = 32'd0;
`endif

    // This unit never talks to the LSQ.
    assign addr        = '0;
    assign data        = '0;
    assign fn3         = 3'd0;
    assign load        = 1'b0;
    assign store       = 1'b0;
    assign new_request = 1'b0;

    wire unused_ok = &{1'b0, lsq_full, load_data, load_complete, rdy_p};

endmodule
